// File: rtl/nonce_report_queue_if.sv
// nonce_report_queue_if: nonce input and host virtual-wire bus for nonce_report_queue.
//   master : hashing cores / virtual-wire source side (drives nonce_valid, nonce_in, host_ack_tag)
//   slave  : the queue itself (drives the report_* probe outputs)
//   nonce_valid/nonce_in : one-cycle golden-nonce strobe and value
//   host_ack_tag         : tag last consumed by the host
//   report_*             : head entry, fill level, drop count, timestamp
interface nonce_report_queue_if #(
  parameter int unsigned NONCE_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned TAG_WIDTH   = 4
) ();
  logic                   nonce_valid;
  logic [NONCE_WIDTH-1:0] nonce_in;
  logic [TAG_WIDTH-1:0]   host_ack_tag;
  logic                   report_valid;
  logic [NONCE_WIDTH-1:0] report_nonce;
  logic [TAG_WIDTH-1:0]   report_tag;
  logic [DEPTH_LOG2:0]    report_level;
  logic [7:0]             report_overflow;
  logic [31:0]            report_timestamp;

  modport master (
    output nonce_valid, nonce_in, host_ack_tag,
    input  report_valid, report_nonce, report_tag, report_level,
           report_overflow, report_timestamp
  );

  modport slave (
    input  nonce_valid, nonce_in, host_ack_tag,
    output report_valid, report_nonce, report_tag, report_level,
           report_overflow, report_timestamp
  );
endinterface

// File: rtl/nonce_report_queue.sv
// nonce_report_queue: buffers golden nonces and presents them one at a time to the
// host over a JTAG virtual wire; the host pops the head by writing back its tag.
//   clk     : single rising-edge clock
//   reset_n : synchronous active-low reset (flushes the queue)
//   bus     : nonce_report_queue_if.slave (nonce input, host ack, report_* probe)
// Optional: define NONCE_REPORT_TIMESTAMP_EN to capture a free-running cycle count
// per accepted nonce and present it on report_timestamp; otherwise it is tied to 0.
module nonce_report_queue #(
  parameter int unsigned NONCE_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned TAG_WIDTH   = 4
) (
  input logic               clk,
  input logic               reset_n,
  nonce_report_queue_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, SHOW, POP} state_e;

  state_e                 state_q;
  logic [NONCE_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]       wptr_q, rptr_q, wptr_seen_q;
  logic [TAG_WIDTH-1:0]   ack_s1_q, ack_s2_q, tag_q;
  logic                   valid_q;
  logic [NONCE_WIDTH-1:0] nonce_q;
  logic [PTR_W-1:0]       level_q, level_d;
  logic [7:0]             ovf_q, ovf_d;

  logic                   full_c, pop_c, push_c, drop_c, avail_c, ack_hit_c;
  logic [TAG_WIDTH-1:0]   tag_next_c;
  logic [DEPTH_LOG2-1:0]  widx_c, ridx_c;

  // Queue status and handshake decode
  always_comb begin
    widx_c     = wptr_q[DEPTH_LOG2-1:0];
    ridx_c     = rptr_q[DEPTH_LOG2-1:0];
    full_c     = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) && (widx_c == ridx_c);
    pop_c      = (state_q == POP);
    // A pop in this cycle frees the slot a full-queue push needs.
    push_c     = bus.nonce_valid && (!full_c || pop_c);
    drop_c     = bus.nonce_valid && !push_c;
    // Reader sees the write pointer one cycle late, so a fresh entry settles first.
    avail_c    = (wptr_seen_q != rptr_q);
    ack_hit_c  = (ack_s1_q == ack_s2_q) && (ack_s2_q == tag_q);
    // Tag 0 is skipped so the host's power-up ack value never matches.
    tag_next_c = (tag_q == {TAG_WIDTH{1'b1}}) ? TAG_WIDTH'(1) : tag_q + TAG_WIDTH'(1);
  end

  // Level and saturating overflow counters
  always_comb begin
    level_d = level_q;
    ovf_d   = ovf_q;
    unique case ({push_c, pop_c})
      2'b10:   level_d = level_q + PTR_W'(1);
      2'b01:   level_d = level_q - PTR_W'(1);
      default: level_d = level_q;
    endcase
    if (drop_c && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
  end

`ifdef NONCE_REPORT_TIMESTAMP_EN
  logic [31:0] cycle_q;
  logic [31:0] ts_mem_q [DEPTH];
  logic [31:0] ts_q;
`endif

  // Entry storage; flushing is done through the pointers
  always_ff @(posedge clk) begin
    if (reset_n && push_c) begin
      mem_q[widx_c] <= bus.nonce_in;
`ifdef NONCE_REPORT_TIMESTAMP_EN
      ts_mem_q[widx_c] <= cycle_q;
`endif
    end
  end

  // Pointers, ack synchronizer and presentation FSM
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      wptr_seen_q <= '0;
      ack_s1_q    <= '0;
      ack_s2_q    <= '0;
      tag_q       <= TAG_WIDTH'(1);
      valid_q     <= 1'b0;
      nonce_q     <= '0;
      level_q     <= '0;
      ovf_q       <= '0;
`ifdef NONCE_REPORT_TIMESTAMP_EN
      cycle_q     <= '0;
      ts_q        <= '0;
`endif
    end else begin
      ack_s1_q    <= bus.host_ack_tag;
      ack_s2_q    <= ack_s1_q;
      wptr_seen_q <= wptr_q;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
`ifdef NONCE_REPORT_TIMESTAMP_EN
      cycle_q     <= cycle_q + 32'd1;
`endif
      if (push_c) wptr_q <= wptr_q + PTR_W'(1);
      unique case (state_q)
        IDLE: begin
          if (avail_c) begin
            nonce_q <= mem_q[ridx_c];
`ifdef NONCE_REPORT_TIMESTAMP_EN
            ts_q    <= ts_mem_q[ridx_c];
`endif
            valid_q <= 1'b1;
            state_q <= SHOW;
          end
        end
        SHOW: begin
          if (ack_hit_c) state_q <= POP;
        end
        POP: begin
          rptr_q  <= rptr_q + PTR_W'(1);
          tag_q   <= tag_next_c;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.report_valid    = valid_q;
  assign bus.report_nonce    = nonce_q;
  assign bus.report_tag      = tag_q;
  assign bus.report_level    = level_q;
  assign bus.report_overflow = ovf_q;
`ifdef NONCE_REPORT_TIMESTAMP_EN
  assign bus.report_timestamp = ts_q;
`else
  assign bus.report_timestamp = 32'd0;
`endif
endmodule

// File: tb/tb_nonce_report_queue.sv
// tb_nonce_report_queue: directed self-checking bench for nonce_report_queue.
module tb_nonce_report_queue;
  localparam int unsigned NW = 32;
  localparam int unsigned DL = 4;
  localparam int unsigned TW = 4;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  nonce_report_queue_if #(.NONCE_WIDTH(NW), .DEPTH_LOG2(DL), .TAG_WIDTH(TW)) bus_if ();

  nonce_report_queue #(.NONCE_WIDTH(NW), .DEPTH_LOG2(DL), .TAG_WIDTH(TW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input logic v, input int budget, input string tag);
    int n = 0;
    while (bus_if.report_valid !== v && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(bus_if.report_valid), 64'(v));
  endtask

  task automatic do_reset();
    reset_n             = 1'b0;
    bus_if.nonce_valid  = 1'b0;
    bus_if.nonce_in     = '0;
    bus_if.host_ack_tag = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_valid"}, 64'(bus_if.report_valid), 64'd0);
    check({pfx, "_nonce"}, 64'(bus_if.report_nonce), 64'd0);
    check({pfx, "_tag"},   64'(bus_if.report_tag), 64'd1);
    check({pfx, "_level"}, 64'(bus_if.report_level), 64'd0);
    check({pfx, "_ovf"},   64'(bus_if.report_overflow), 64'd0);
    check({pfx, "_ts"},    64'(bus_if.report_timestamp), 64'd0);
  endtask

  initial begin
    logic [NW-1:0] abc [3];
    logic [TW-1:0] bad_acks [3];
    logic [TW-1:0] exp_tag;

    abc[0] = 32'hA0A0_0001;
    abc[1] = 32'hB0B0_0002;
    abc[2] = 32'hC0C0_0003;
    bad_acks[0] = 4'd0;
    bad_acks[1] = 4'd2;
    bad_acks[2] = 4'd15;

    // Reset values and first-entry latency
    do_reset();
    check_reset_state("rst");
    bus_if.nonce_in    = 32'hDEADBEEF;
    bus_if.nonce_valid = 1'b1;
    tick();
    bus_if.nonce_valid = 1'b0;
    check("lat_n0_valid", 64'(bus_if.report_valid), 64'd0);
    tick();
    check("lat_n1_valid", 64'(bus_if.report_valid), 64'd0);
    tick();
    check("lat_n2_valid", 64'(bus_if.report_valid), 64'd1);
    check("lat_n2_nonce", 64'(bus_if.report_nonce), 64'hDEADBEEF);
    check("lat_n2_tag",   64'(bus_if.report_tag), 64'd1);
    check("lat_n2_level", 64'(bus_if.report_level), 64'd1);

    // Mismatched acks are ignored
    for (int i = 0; i < 3; i++) begin
      bus_if.host_ack_tag = bad_acks[i];
      repeat (5) tick();
      check($sformatf("noack%0d_valid", bad_acks[i]), 64'(bus_if.report_valid), 64'd1);
      check($sformatf("noack%0d_level", bad_acks[i]), 64'(bus_if.report_level), 64'd1);
    end

    // Matching ack: pop decided at k+2, entry gone after k+3
    bus_if.host_ack_tag = 4'd1;
    repeat (3) tick();
    check("ack_k2_valid", 64'(bus_if.report_valid), 64'd1);
    tick();
    check("ack_k3_valid", 64'(bus_if.report_valid), 64'd0);
    check("ack_k3_level", 64'(bus_if.report_level), 64'd0);
    check("ack_k3_tag",   64'(bus_if.report_tag), 64'd2);
    repeat (6) tick();
    check("ack_hold_level", 64'(bus_if.report_level), 64'd0);
    check("ack_hold_valid", 64'(bus_if.report_valid), 64'd0);
    check("ack_hold_tag",   64'(bus_if.report_tag), 64'd2);

    // Three back-to-back pushes presented in order
    do_reset();
    bus_if.nonce_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_if.nonce_in = abc[i];
      tick();
    end
    bus_if.nonce_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_valid(1'b1, 8, $sformatf("abc%0d_show", i));
      check($sformatf("abc%0d_nonce", i), 64'(bus_if.report_nonce), 64'(abc[i]));
      check($sformatf("abc%0d_tag", i),   64'(bus_if.report_tag), 64'(i + 1));
      check($sformatf("abc%0d_level", i), 64'(bus_if.report_level), 64'(3 - i));
      bus_if.host_ack_tag = TW'(i + 1);
      wait_valid(1'b0, 8, $sformatf("abc%0d_pop", i));
    end
    repeat (4) tick();
    check("abc_end_valid", 64'(bus_if.report_valid), 64'd0);
    check("abc_end_level", 64'(bus_if.report_level), 64'd0);

    // Fill past capacity: 16 held, 4 dropped
    do_reset();
    bus_if.nonce_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus_if.nonce_in = NW'(100 + i);
      tick();
    end
    bus_if.nonce_valid = 1'b0;
    tick();
    check("fill_level", 64'(bus_if.report_level), 64'd16);
    check("fill_ovf",   64'(bus_if.report_overflow), 64'd4);
    check("fill_head",  64'(bus_if.report_nonce), 64'd100);

    // Push in the exact POP cycle while full is accepted
    bus_if.host_ack_tag = 4'd1;
    repeat (3) tick();
    check("pwf_pre_valid", 64'(bus_if.report_valid), 64'd1);
    bus_if.nonce_in    = 32'hCAFE0001;
    bus_if.nonce_valid = 1'b1;
    tick();
    bus_if.nonce_valid = 1'b0;
    check("pwf_level", 64'(bus_if.report_level), 64'd16);
    check("pwf_ovf",   64'(bus_if.report_overflow), 64'd4);
    check("pwf_valid", 64'(bus_if.report_valid), 64'd0);
    tick();
    check("pwf_next_valid", 64'(bus_if.report_valid), 64'd1);
    check("pwf_next_nonce", 64'(bus_if.report_nonce), 64'd101);
    check("pwf_next_tag",   64'(bus_if.report_tag), 64'd2);

    // Overflow saturation
    bus_if.nonce_valid = 1'b1;
    repeat (300) tick();
    bus_if.nonce_valid = 1'b0;
    tick();
    check("sat_ovf",   64'(bus_if.report_overflow), 64'd255);
    check("sat_level", 64'(bus_if.report_level), 64'd16);

    // Tag wrap: 1..15 then 1
    do_reset();
    for (int i = 0; i < 16; i++) begin
      exp_tag = TW'((i % 15) + 1);
      bus_if.nonce_in    = NW'(32'h500 + i);
      bus_if.nonce_valid = 1'b1;
      tick();
      bus_if.nonce_valid = 1'b0;
      wait_valid(1'b1, 8, $sformatf("wrap%0d_show", i));
      check($sformatf("wrap%0d_tag", i), 64'(bus_if.report_tag), 64'(exp_tag));
      bus_if.host_ack_tag = exp_tag;
      wait_valid(1'b0, 8, $sformatf("wrap%0d_pop", i));
    end

    // Reset while an entry is shown flushes everything
    bus_if.host_ack_tag = '0;
    bus_if.nonce_in     = 32'h1234_5678;
    bus_if.nonce_valid  = 1'b1;
    tick();
    bus_if.nonce_valid  = 1'b0;
    wait_valid(1'b1, 8, "mid_show");
    reset_n = 1'b0;
    tick();
    check_reset_state("mid_rst");
    reset_n = 1'b1;
    repeat (4) tick();
    check("mid_after_valid", 64'(bus_if.report_valid), 64'd0);
    check("mid_after_level", 64'(bus_if.report_level), 64'd0);
    check("mid_after_tag",   64'(bus_if.report_tag), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
